// File: rtl/stats_counter_bank_if.sv
// Read-port bundle for stats_counter_bank: the requester issues an index and bank select,
// and the bank returns data, valid and an out-of-range error one cycle later.
interface stats_counter_bank_if #(
    parameter int NUM_EVENTS = 28,
    parameter int COUNTER_W  = 32
) ();
    localparam int IDX_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

    logic                 rd_en;
    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_shadow;
    logic                 rd_valid;
    logic [COUNTER_W-1:0] rd_data;
    logic                 rd_err;

    modport master (
        output rd_en, rd_idx, rd_shadow,
        input  rd_valid, rd_data, rd_err
    );

    modport slave (
        input  rd_en, rd_idx, rd_shadow,
        output rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/stats_counter_bank.sv
// Event counter bank: multi-count increments, wrap/saturate, sticky overflow, snapshot shadow bank.
// Read port has a fixed 1-cycle latency; no backpressure, a new read may be issued every cycle.
module stats_counter_bank #(
    parameter int NUM_EVENTS = 28,
    parameter int COUNTER_W  = 32,
    parameter int INC_W      = 2,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_EVENTS*INC_W-1:0] inc,
    input  logic                        count_en,
    input  logic                        freeze,
    input  logic                        clear,
    input  logic                        snap,
    stats_counter_bank_if.slave         rd,
    output logic [NUM_EVENTS-1:0]       overflow
);
    localparam int IDX_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

    typedef logic [COUNTER_W-1:0] cnt_t;

    cnt_t                  live     [NUM_EVENTS];
    cnt_t                  shadow   [NUM_EVENTS];
    cnt_t                  live_nxt [NUM_EVENTS];
    logic [COUNTER_W:0]    sum      [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] ovf_nxt;
    cnt_t                  rd_sel;
    logic                  rd_hit;

    // One extra bit of headroom exposes the carry that marks an overflow.
    always_comb begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
            sum[i]      = {1'b0, live[i]} + (COUNTER_W+1)'(inc[i*INC_W +: INC_W]);
            live_nxt[i] = sum[i][COUNTER_W-1:0];
            ovf_nxt[i]  = overflow[i];
            if (sum[i][COUNTER_W]) begin
                ovf_nxt[i] = 1'b1;
                if (SATURATE) begin
                    live_nxt[i] = '1;
                end
            end
        end
    end

    // An index that matches no counter leaves rd_hit low and rd_sel zero.
    always_comb begin
        rd_sel = '0;
        rd_hit = 1'b0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (rd.rd_idx == IDX_W'(i)) begin
                rd_hit = 1'b1;
                rd_sel = rd.rd_shadow ? shadow[i] : live[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
            overflow    <= '0;
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
            rd.rd_err   <= 1'b0;
        end else begin
            if (snap) begin
                for (int i = 0; i < NUM_EVENTS; i++) begin
                    shadow[i] <= live[i];
                end
            end

            if (clear) begin
                for (int i = 0; i < NUM_EVENTS; i++) begin
                    live[i] <= '0;
                end
                overflow <= '0;
            end else if (count_en && !freeze) begin
                for (int i = 0; i < NUM_EVENTS; i++) begin
                    live[i] <= live_nxt[i];
                end
                overflow <= ovf_nxt;
            end

            // rd_data holds its last value between reads.
            rd.rd_valid <= rd.rd_en;
            if (rd.rd_en) begin
                rd.rd_data <= rd_sel;
                rd.rd_err  <= !rd_hit;
            end else begin
                rd.rd_err  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stats_counter_bank.sv
// Directed bench for stats_counter_bank: a default 28x32 wrap bank plus two 4x8 banks
// (wrap and saturate) sharing the control strobes.
module tb_stats_counter_bank;
    localparam int NE = 28;

    logic            clk;
    logic            rst;
    logic [NE*2-1:0] inc;
    logic [7:0]      inc_s;
    logic            count_en;
    logic            freeze;
    logic            clear;
    logic            snap;
    logic [NE-1:0]   overflow;
    logic [3:0]      ovf_w;
    logic [3:0]      ovf_s;

    int          tests;
    int          fails;
    logic [63:0] exp5 [5];

    stats_counter_bank_if #(.NUM_EVENTS(NE), .COUNTER_W(32)) rd_m ();
    stats_counter_bank_if #(.NUM_EVENTS(4),  .COUNTER_W(8))  rd_w ();
    stats_counter_bank_if #(.NUM_EVENTS(4),  .COUNTER_W(8))  rd_s ();

    stats_counter_bank #(.NUM_EVENTS(NE), .COUNTER_W(32), .INC_W(2), .SATURATE(1'b0)) dut (
        .clk(clk), .rst(rst), .inc(inc), .count_en(count_en), .freeze(freeze),
        .clear(clear), .snap(snap), .rd(rd_m), .overflow(overflow)
    );

    stats_counter_bank #(.NUM_EVENTS(4), .COUNTER_W(8), .INC_W(2), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .inc(inc_s), .count_en(count_en), .freeze(freeze),
        .clear(clear), .snap(snap), .rd(rd_w), .overflow(ovf_w)
    );

    stats_counter_bank #(.NUM_EVENTS(4), .COUNTER_W(8), .INC_W(2), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .inc(inc_s), .count_en(count_en), .freeze(freeze),
        .clear(clear), .snap(snap), .rd(rd_s), .overflow(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; issues one read and samples the response a cycle later.
    task automatic read_chk(input string tag, input int bank, input int idx, input logic shadow,
                            input logic [63:0] exp_data, input logic exp_err);
        logic [63:0] d;
        logic        v;
        logic        e;
        case (bank)
            0:       begin rd_m.rd_en = 1'b1; rd_m.rd_idx = 5'(idx); rd_m.rd_shadow = shadow; end
            1:       begin rd_w.rd_en = 1'b1; rd_w.rd_idx = 2'(idx); rd_w.rd_shadow = shadow; end
            default: begin rd_s.rd_en = 1'b1; rd_s.rd_idx = 2'(idx); rd_s.rd_shadow = shadow; end
        endcase
        @(negedge clk);
        rd_m.rd_en = 1'b0;
        rd_w.rd_en = 1'b0;
        rd_s.rd_en = 1'b0;
        case (bank)
            0:       begin v = rd_m.rd_valid; d = 64'(rd_m.rd_data); e = rd_m.rd_err; end
            1:       begin v = rd_w.rd_valid; d = 64'(rd_w.rd_data); e = rd_w.rd_err; end
            default: begin v = rd_s.rd_valid; d = 64'(rd_s.rd_data); e = rd_s.rd_err; end
        endcase
        check_val({tag, ".vld"}, 64'(v), 64'd1);
        check_val({tag, ".dat"}, d, exp_data);
        check_val({tag, ".err"}, 64'(e), 64'(exp_err));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        inc = '0;
        inc_s = '0;
        count_en = 1'b0;
        freeze = 1'b0;
        clear = 1'b0;
        snap = 1'b0;
        rd_m.rd_en = 1'b0; rd_m.rd_idx = '0; rd_m.rd_shadow = 1'b0;
        rd_w.rd_en = 1'b0; rd_w.rd_idx = '0; rd_w.rd_shadow = 1'b0;
        rd_s.rd_en = 1'b0; rd_s.rd_idx = '0; rd_s.rd_shadow = 1'b0;

        // 1: reset, then ten single counts on event 0
        repeat (3) @(negedge clk);
        check_val("rst.vld", 64'(rd_m.rd_valid), 64'd0);
        check_val("rst.dat", 64'(rd_m.rd_data), 64'd0);
        check_val("rst.err", 64'(rd_m.rd_err), 64'd0);
        check_val("rst.ovf", 64'(overflow), 64'd0);
        rst = 1'b1;
        inc[1:0] = 2'd1;
        count_en = 1'b1;
        repeat (10) @(negedge clk);
        inc = '0;
        count_en = 1'b0;
        read_chk("basic", 0, 0, 1'b0, 64'd10, 1'b0);
        check_val("basic.ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        check_val("idle.vld", 64'(rd_m.rd_valid), 64'd0);
        check_val("idle.hold", 64'(rd_m.rd_data), 64'd10);

        // 2: multi-increment with a freeze window
        inc[11:10] = 2'd3;
        inc[13:12] = 2'd2;
        count_en = 1'b1;
        repeat (4) @(negedge clk);
        freeze = 1'b1;
        repeat (2) @(negedge clk);
        freeze = 1'b0;
        count_en = 1'b0;
        inc = '0;
        read_chk("multi5", 0, 5, 1'b0, 64'd12, 1'b0);
        read_chk("multi6", 0, 6, 1'b0, 64'd8, 1'b0);

        // 3: 8-bit wrap vs saturate from 254
        inc_s[1:0] = 2'd2;
        count_en = 1'b1;
        repeat (127) @(negedge clk);
        check_val("pre.ovf_w", 64'(ovf_w), 64'd0);
        inc_s[1:0] = 2'd3;
        @(negedge clk);
        inc_s = '0;
        count_en = 1'b0;
        check_val("wrap.ovf", 64'(ovf_w), 64'h1);
        check_val("sat.ovf", 64'(ovf_s), 64'h1);
        read_chk("wrap", 1, 0, 1'b0, 64'd1, 1'b0);
        read_chk("sat", 2, 0, 1'b0, 64'd255, 1'b0);
        inc_s[1:0] = 2'd1;
        count_en = 1'b1;
        @(negedge clk);
        inc_s = '0;
        count_en = 1'b0;
        read_chk("sat.hold", 2, 0, 1'b0, 64'd255, 1'b0);
        read_chk("wrap.more", 1, 0, 1'b0, 64'd2, 1'b0);
        check_val("sat.ovf2", 64'(ovf_s), 64'h1);
        check_val("main.ovf", 64'(overflow), 64'd0);

        // 4: snap and clear in the same cycle
        inc[5:4] = 2'd2;
        count_en = 1'b1;
        repeat (20) @(negedge clk);
        inc[5:4] = 2'd3;
        snap = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        snap = 1'b0;
        clear = 1'b0;
        count_en = 1'b0;
        inc = '0;
        check_val("clr.ovf_w", 64'(ovf_w), 64'd0);
        check_val("clr.ovf", 64'(overflow), 64'd0);
        read_chk("shd2", 0, 2, 1'b1, 64'd40, 1'b0);
        read_chk("live2", 0, 2, 1'b0, 64'd0, 1'b0);
        read_chk("shd5", 0, 5, 1'b1, 64'd12, 1'b0);
        read_chk("live5", 0, 5, 1'b0, 64'd0, 1'b0);

        // 5: out-of-range index, same-cycle increment, back-to-back reads
        read_chk("oor", 0, NE, 1'b0, 64'd0, 1'b1);
        inc[3:2] = 2'd1;
        count_en = 1'b1;
        repeat (7) @(negedge clk);
        rd_m.rd_en = 1'b1;
        rd_m.rd_idx = 5'd1;
        rd_m.rd_shadow = 1'b0;
        @(negedge clk);
        rd_m.rd_en = 1'b0;
        count_en = 1'b0;
        inc = '0;
        check_val("samecyc.vld", 64'(rd_m.rd_valid), 64'd1);
        check_val("samecyc.dat", 64'(rd_m.rd_data), 64'd7);
        read_chk("after", 0, 1, 1'b0, 64'd8, 1'b0);

        inc[1:0] = 2'd1;
        inc[5:4] = 2'd1;
        inc[7:6] = 2'd2;
        inc[9:8] = 2'd3;
        count_en = 1'b1;
        @(negedge clk);
        inc = '0;
        count_en = 1'b0;
        exp5[0] = 64'd1; exp5[1] = 64'd8; exp5[2] = 64'd1; exp5[3] = 64'd2; exp5[4] = 64'd3;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin
                check_val("b2b.vld", 64'(rd_m.rd_valid), 64'd1);
                check_val("b2b.dat", 64'(rd_m.rd_data), exp5[k-1]);
            end
            rd_m.rd_en = (k < 5);
            rd_m.rd_idx = 5'(k);
            @(negedge clk);
        end
        check_val("b2b.end", 64'(rd_m.rd_valid), 64'd0);

        // 6: asynchronous reset with a read response showing and counting active
        inc[1:0] = 2'd1;
        count_en = 1'b1;
        rd_m.rd_en = 1'b1;
        rd_m.rd_idx = 5'd0;
        @(posedge clk);
        #2;
        check_val("pre_rst.vld", 64'(rd_m.rd_valid), 64'd1);
        check_val("pre_rst.dat", 64'(rd_m.rd_data), 64'd1);
        rst = 1'b0;
        #1;
        check_val("arst.vld", 64'(rd_m.rd_valid), 64'd0);
        check_val("arst.dat", 64'(rd_m.rd_data), 64'd0);
        check_val("arst.err", 64'(rd_m.rd_err), 64'd0);
        check_val("arst.ovf", 64'(overflow), 64'd0);
        rd_m.rd_en = 1'b0;
        count_en = 1'b0;
        inc = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rel.vld", 64'(rd_m.rd_valid), 64'd0);
        @(negedge clk);
        check_val("rel.vld2", 64'(rd_m.rd_valid), 64'd0);
        read_chk("rel.live0", 0, 0, 1'b0, 64'd0, 1'b0);
        read_chk("rel.shd2", 0, 2, 1'b1, 64'd0, 1'b0);
        read_chk("rel.sat0", 2, 0, 1'b0, 64'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
